// File: rtl/audio_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package  : audio_pkg                                                      |
// | Purpose  : Shared constants and state type for the audio serializer.      |
// |            SAMPLE_W - width of one {left, right} sample word              |
// |            CH_W     - width of one channel within the sample              |
// |            ser_state_t - serializer FSM states                            |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package audio_pkg;

  localparam int SAMPLE_W = 32;
  localparam int CH_W     = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ser_state_t;

endpackage : audio_pkg
`default_nettype wire

// File: rtl/sclk_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sclk_gen                                                       |
// | Purpose  : Bit-period divider for the serial DAC link. Produces the       |
// |            registered bit clock and a strobe marking the last clk cycle   |
// |            of each bit period.                                            |
// | Ports    : clk      - system clock                                        |
// |            n_rst    - synchronous active-low reset                        |
// |            run      - 1 = divider counting, 0 = held at zero              |
// |            sclk     - registered bit clock, high for the second half      |
// |            bit_tick - high in the last cycle of a bit period (wrap edge)  |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module sclk_gen #(
  parameter int SCLK_DIV = 4
) (
  input  logic clk,
  input  logic n_rst,
  input  logic run,
  output logic sclk,
  output logic bit_tick
);

  localparam int CNT_W = $clog2(SCLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(SCLK_DIV / 2);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             sclk_q, sclk_d;

  always_comb begin
    div_cnt_d = '0;
    if (run) begin
      div_cnt_d = (div_cnt_q == LAST) ? '0 : div_cnt_q + 1'b1;
    end
    // sclk is computed from the next count so the flop always equals
    // (div_cnt >= SCLK_DIV/2) with no extra cycle of lag.
    sclk_d = (div_cnt_d >= HALF);
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      div_cnt_q <= '0;
      sclk_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sclk_q    <= sclk_d;
    end
  end

  assign sclk     = sclk_q;
  assign bit_tick = run && (div_cnt_q == LAST);

endmodule : sclk_gen
`default_nettype wire

// File: rtl/audio_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : audio_serializer                                               |
// | Purpose  : Serializes {left, right} samples MSB-first onto a              |
// |            left-justified DAC link, with a one-entry hold register        |
// |            between the producer strobe and frame timing.                  |
// | Ports    : clk          - system clock                                    |
// |            n_rst        - synchronous active-low reset                    |
// |            tx_en        - run link; 0 stops at the next frame boundary    |
// |            sample_valid - producer strobe                                 |
// |            sample_data  - {left, right} sample                            |
// |            sample_ready - hold register empty                             |
// |            sclk         - serial bit clock                                |
// |            lrclk        - word select, 0 = left, 1 = right                |
// |            sdata        - serial data, MSB first                          |
// |            underrun     - pulse: frame started with nothing held          |
// |            overflow     - pulse: strobe arrived while hold was full       |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module audio_serializer
  import audio_pkg::*;
#(
  parameter int DATA_W   = SAMPLE_W,
  parameter int SCLK_DIV = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              tx_en,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              sample_ready,
  output logic              sclk,
  output logic              lrclk,
  output logic              sdata,
  output logic              underrun,
  output logic              overflow
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  ser_state_t        state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              underrun_q, underrun_d;
  logic              overflow_q, overflow_d;

  logic              bit_tick;
  logic              frame_end;

  sclk_gen #(
    .SCLK_DIV (SCLK_DIV)
  ) u_sclk_gen (
    .clk      (clk),
    .n_rst    (n_rst),
    .run      (state_q == RUN),
    .sclk     (sclk),
    .bit_tick (bit_tick)
  );

  assign frame_end = bit_tick && (bit_cnt_q == LAST_BIT);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    underrun_d  = 1'b0;
    overflow_d  = sample_valid && hold_full_q;

    // Accept and consume are mutually exclusive: accept needs the hold
    // empty, consume needs it full.
    if (sample_valid && !hold_full_q) begin
      hold_d      = sample_data;
      hold_full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (tx_en && hold_full_q) begin
          state_d     = RUN;
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          bit_cnt_d   = '0;
        end
      end
      RUN: begin
        if (bit_tick) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          shift_d   = {shift_q[DATA_W-2:0], 1'b0};
          if (frame_end) begin
            if (!tx_en) begin
              // Clearing shift here drops sdata to 0 in IDLE; bit_cnt has
              // already wrapped to 0 so lrclk drops too.
              state_d = IDLE;
              shift_d = '0;
            end else if (hold_full_q) begin
              shift_d     = hold_q;
              hold_full_d = 1'b0;
            end else begin
              shift_d    = '0;
              underrun_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      underrun_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      underrun_q  <= underrun_d;
      overflow_q  <= overflow_d;
    end
  end

  // The right channel occupies bit slots CH_W..2*CH_W-1, so word select is
  // simply the bit-counter MSB; taking a flop bit directly keeps it glitch-free.
  assign lrclk        = bit_cnt_q[$clog2(CH_W)];
  assign sdata        = shift_q[DATA_W-1];
  assign underrun     = underrun_q;
  assign overflow     = overflow_q;
  assign sample_ready = !hold_full_q;

endmodule : audio_serializer
`default_nettype wire

// File: tb/tb_audio_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_audio_serializer                                            |
// | Purpose  : Self-checking bench for audio_serializer. A frame-position     |
// |            model predicts every output each cycle; a DAC-side receiver    |
// |            reassembles words for literal checks of directed scenarios.    |
// | Revision : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_audio_serializer;

  localparam int DIV   = 4;
  localparam int FRAME = 32 * DIV;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        tx_en = 1'b0;
  logic        sample_valid = 1'b0;
  logic [31:0] sample_data = '0;
  logic        sample_ready, sclk, lrclk, sdata, underrun, overflow;

  audio_serializer #(.DATA_W(32), .SCLK_DIV(DIV)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .tx_en        (tx_en),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .sclk         (sclk),
    .lrclk        (lrclk),
    .sdata        (sdata),
    .underrun     (underrun),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model: frame position arithmetic ----------
  bit          m_run = 1'b0;
  int          m_t = 0;
  logic [31:0] m_word = '0;
  bit          m_full = 1'b0;
  logic [31:0] m_hold = '0;
  bit          m_und = 1'b0;
  bit          m_ovf = 1'b0;
  int          cyc = 0;

  always @(posedge clk) begin : model
    bit acc;
    cyc++;
    if (!n_rst) begin
      m_run = 0; m_t = 0; m_word = '0; m_full = 0; m_hold = '0;
      m_und = 0; m_ovf = 0;
    end else begin
      acc   = sample_valid && !m_full;
      m_ovf = sample_valid && m_full;
      m_und = 0;
      if (!m_run) begin
        if (tx_en && m_full) begin
          m_run = 1; m_t = 0; m_word = m_hold; m_full = 0;
        end
      end else if (m_t == FRAME - 1) begin
        m_t = 0;
        if (!tx_en) m_run = 0;
        else if (m_full) begin m_word = m_hold; m_full = 0; end
        else begin m_word = '0; m_und = 1; end
      end else begin
        m_t++;
      end
      if (acc) begin m_hold = sample_data; m_full = 1; end
    end
  end

  always @(negedge clk) begin : compare
    logic [5:0] e, a;
    if (chk_en) begin
      e[5] = !m_full;
      e[4] = m_run && ((m_t % DIV) >= DIV / 2);
      e[3] = m_run && ((m_t / DIV) >= 16);
      e[2] = m_run && m_word[31 - m_t / DIV];
      e[1] = m_und;
      e[0] = m_ovf;
      a = {sample_ready, sclk, lrclk, sdata, underrun, overflow};
      check("outputs{rdy,sclk,lr,sd,und,ovf}", 32'(a), 32'(e));
    end
  end

  // ---------------- DAC-side receiver ----------------
  logic [31:0] rx_word [16];
  int          rx_start [16];
  int          rx_count = 0;
  int          rx_bits = 0;
  logic [31:0] rx_sr = '0;
  logic        prev_sclk = 1'b0;
  int          und_count = 0;

  always @(negedge clk) begin : receiver
    if (!n_rst) begin
      rx_bits = 0;
    end else if (sclk === 1'b1 && prev_sclk === 1'b0) begin
      rx_sr = {rx_sr[30:0], sdata};
      if (rx_bits == 0 && rx_count < 16) rx_start[rx_count] = cyc;
      rx_bits++;
      if (rx_bits == 32) begin
        if (rx_count < 16) rx_word[rx_count] = rx_sr;
        rx_count++;
        rx_bits = 0;
      end
    end
    if (underrun === 1'b1) und_count++;
    prev_sclk = sclk;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_rx(input int n);
    int k;
    k = 0;
    while (rx_count < n && k < 2000) begin
      step();
      k++;
    end
    check("wait_rx_frames", 32'(rx_count >= n), 32'd1);
  endtask

  task automatic strobe(input logic [31:0] d);
    sample_valid = 1'b1;
    sample_data  = d;
    step();
    sample_valid = 1'b0;
  endtask

  logic [31:0] x_val, y_val, z_val, w_val;

  initial begin
    // Reset
    n_rst = 1'b0;
    steps(2);
    chk_en = 1'b1;
    n_rst  = 1'b1;
    @(negedge clk);
    check("reset_outputs", 32'({sample_ready, sclk, lrclk, sdata, underrun, overflow}), 32'b100000);

    // 1: single sample, latency and first-bit timing
    step();
    tx_en = 1'b1;
    strobe(32'hA5A5_0F0F);           // accepted at E0
    @(negedge clk);
    check("t1_ready_after_accept", 32'(sample_ready), 32'd0);
    check("t1_sdata_before_start", 32'(sdata), 32'd0);
    step();                           // E1: frame starts
    @(negedge clk);
    check("t1_first_bit", 32'({sclk, lrclk, sdata}), 32'b001);
    steps(2);                         // E3: two cycles into bit 0
    @(negedge clk);
    check("t1_sclk_rise", 32'(sclk), 32'd1);

    // 2: back-to-back second sample
    steps(40);
    strobe(32'h8000_0001);
    @(negedge clk);
    check("t2_ready_held", 32'(sample_ready), 32'd0);
    wait_rx(2);
    check("t1_frame_word", rx_word[0], 32'hA5A5_0F0F);
    check("t2_frame_word", rx_word[1], 32'h8000_0001);
    check("t2_frame_gap", 32'(rx_start[1] - rx_start[0]), 32'(FRAME));

    // 3: underrun frame of zeros
    wait_rx(3);
    check("t3_zero_frame", rx_word[2], 32'h0);
    check("t3_underrun_count", 32'(und_count), 32'd1);

    // 4: two strobes with hold full -> second one overflows
    steps(10);
    x_val = $urandom;
    y_val = ~x_val;
    sample_valid = 1'b1; sample_data = x_val; step();
    sample_data = y_val; step();
    sample_valid = 1'b0;
    @(negedge clk);
    check("t4_overflow_pulse", 32'(overflow), 32'd1);
    check("t4_underrun_count", 32'(und_count), 32'd2);

    // 5: drop tx_en around bit 10 of the x frame
    wait_rx(4);
    steps(42);
    tx_en = 1'b0;
    wait_rx(5);
    check("t4_held_word", rx_word[4], x_val);
    steps(5);
    @(negedge clk);
    check("t5_idle_outputs", 32'({sclk, lrclk, sdata}), 32'b000);
    z_val = $urandom | 32'h8000_0000;
    strobe(z_val);
    steps(8);
    @(negedge clk);
    check("t5_idle_while_held", 32'({sample_ready, sclk, lrclk, sdata}), 32'b0000);
    tx_en = 1'b1;
    step();
    @(negedge clk);
    check("t5_restart_first_bit", 32'({sdata, sample_ready}), 32'b11);

    // 6: reset around bit 20 with a sample held
    w_val = $urandom;
    strobe(w_val);
    steps(78);
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    @(negedge clk);
    check("t6_reset_outputs", 32'({sample_ready, sclk, lrclk, sdata, underrun, overflow}), 32'b100000);
    steps(6);
    @(negedge clk);
    check("t6_hold_discarded", 32'({sample_ready, sclk}), 32'b10);

    // Randomized traffic against the model
    for (int i = 0; i < 6000; i++) begin
      sample_valid = ($urandom_range(0, 9) == 0);
      sample_data  = $urandom;
      if ($urandom_range(0, 299) == 0) tx_en = ~tx_en;
      n_rst = ($urandom_range(0, 1999) != 0);
      step();
    end
    sample_valid = 1'b0;
    n_rst = 1'b1;
    steps(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_audio_serializer
`default_nettype wire
